// File: rtl/muldiv_pkg.sv
// Shared op codes, op enum, FSM state enum and op-class helpers for the
// sequential multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OPC_MUL    = 3'd0;
  localparam logic [2:0] OPC_MULH   = 3'd1;
  localparam logic [2:0] OPC_MULHSU = 3'd2;
  localparam logic [2:0] OPC_MULHU  = 3'd3;
  localparam logic [2:0] OPC_DIV    = 3'd4;
  localparam logic [2:0] OPC_DIVU   = 3'd5;
  localparam logic [2:0] OPC_REM    = 3'd6;
  localparam logic [2:0] OPC_REMU   = 3'd7;

  typedef enum logic [2:0] {
    OP_MUL    = OPC_MUL,
    OP_MULH   = OPC_MULH,
    OP_MULHSU = OPC_MULHSU,
    OP_MULHU  = OPC_MULHU,
    OP_DIV    = OPC_DIV,
    OP_DIVU   = OPC_DIVU,
    OP_REM    = OPC_REM,
    OP_REMU   = OPC_REMU
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_div_op(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU) || (o == OP_REM) || (o == OP_REMU);
  endfunction

  function automatic logic is_rem_op(input op_e o);
    return (o == OP_REM) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step, or (with MULDIV_DIV_EN)
// a restoring-divide trial-subtract step. acc holds {hi, lo} of the 2W state.
module muldiv_step #(
  parameter int W = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic           is_div,
`endif
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  output logic [2*W-1:0] acc_nxt
);

  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
  end

`ifdef MULDIV_DIV_EN
  logic [W:0]   rem_sh;
  logic [W+1:0] diff;

  // Remainder shifted left by one keeps its carry-out bit for the trial subtract.
  always_comb begin
    rem_sh = acc[2*W-1:W-1];
    diff   = {1'b0, rem_sh} - {2'b00, opnd};
    if (!is_div) begin
      acc_nxt = {sum, acc[W-1:1]};
    end else if (diff[W+1]) begin
      acc_nxt = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
    end else begin
      acc_nxt = {diff[W-1:0], acc[W-2:0], 1'b1};
    end
  end
`else
  always_comb begin
    acc_nxt = {sum, acc[W-1:1]};
  end
`endif

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M/RV64M multiply/divide unit, one iteration per cycle.
// Division ops are built only when macro MULDIV_DIV_EN is defined.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] SrcA,
  input  logic [W-1:0] SrcB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Result,
  output logic         illegal
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_e         state, state_nxt;
  op_e            op_q;
  logic [2*W-1:0] acc, acc_nxt, prod;
  logic [W-1:0]   opnd;
  logic [CW-1:0]  cnt;
  logic           neg_q;

  logic           accept, a_signed, b_signed, a_neg, b_neg, neg_acc;
  logic           short_path, short_ill;
  logic [W-1:0]   a_mag, b_mag, short_res, fin_res;

  function automatic logic [2*W-1:0] fix_wide(input logic [2*W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

`ifdef MULDIV_DIV_EN
  function automatic logic [W-1:0] fix_narrow(input logic [W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
`endif

  assign in_ready  = (state == IDLE) && !flush && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Operand conditioning: magnitudes, result sign, and single-cycle cases.
  always_comb begin
    a_signed   = (op == OPC_MULH) || (op == OPC_MULHSU) || (op == OPC_DIV) || (op == OPC_REM);
    b_signed   = (op == OPC_MULH) || (op == OPC_DIV) || (op == OPC_REM);
    a_neg      = a_signed & SrcA[W-1];
    b_neg      = b_signed & SrcB[W-1];
    a_mag      = a_neg ? -SrcA : SrcA;
    b_mag      = b_neg ? -SrcB : SrcB;
    neg_acc    = (op == OPC_REM) ? a_neg : (a_neg ^ b_neg);
    short_path = 1'b0;
    short_res  = '0;
    short_ill  = 1'b0;
`ifdef MULDIV_DIV_EN
    if (op[2] && (SrcB == '0)) begin
      short_path = 1'b1;
      short_res  = op[1] ? SrcA : '1;
    end else if (op[2] && !op[0] && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1)) begin
      short_path = 1'b1;
      short_res  = op[1] ? '0 : SrcA;
    end
`else
    if (op[2]) begin
      short_path = 1'b1;
      short_ill  = 1'b1;
    end
`endif
  end

  muldiv_step #(.W(W)) u_step (
`ifdef MULDIV_DIV_EN
    .is_div  (is_div_op(op_q)),
`endif
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (acc_nxt)
  );

  // Sign fix-up applied to the state produced by the final iteration.
  always_comb begin
    prod    = fix_wide(acc_nxt, neg_q);
    fin_res = (op_q == OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];
`ifdef MULDIV_DIV_EN
    if (is_div_op(op_q)) begin
      fin_res = fix_narrow(is_rem_op(op_q) ? acc_nxt[2*W-1:W] : acc_nxt[W-1:0], neg_q);
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = short_path ? DONE : CALC;
      CALC:    if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_MUL;
      acc     <= '0;
      opnd    <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      Result  <= '0;
      illegal <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_e'(op);
        acc     <= {{W{1'b0}}, a_mag};
        opnd    <= b_mag;
        cnt     <= '0;
        neg_q   <= neg_acc;
        Result  <= short_res;
        illegal <= short_ill;
      end else if (state == CALC) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) Result <= fin_res;
      end
      // Leaving DONE or aborting discards whatever result was held.
      if (flush || ((state == DONE) && out_ready)) begin
        Result  <= '0;
        illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expectations are queued at accept and
// compared when the result is presented. Adapts to MULDIV_DIV_EN.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk, rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [2:0]   op;
  logic [W-1:0] SrcA, SrcB, Result;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] res;
    logic         ill;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   acc_cnt = 0;
  bit   lat_done = 0;

  muldiv_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int acyc);
    exp_t        e;
    longint      sa, sbv;
    logic [63:0] p;
    sa        = longint'($signed(a));
    sbv       = longint'($signed(b));
    e.op      = o;
    e.ill     = 1'b0;
    e.lat     = W + 1;
    e.acc_cyc = acyc;
    e.res     = '0;
    p         = '0;
    case (o)
      OPC_MUL:    begin p = {32'b0, a} * {32'b0, b};                   e.res = p[31:0];  end
      OPC_MULH:   begin p = sa * sbv;                                  e.res = p[63:32]; end
      OPC_MULHSU: begin p = sa * longint'({32'b0, b});                 e.res = p[63:32]; end
      OPC_MULHU:  begin p = {32'b0, a} * {32'b0, b};                   e.res = p[63:32]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 0) begin
          e.lat = 1;
          e.res = o[1] ? a : 32'hFFFF_FFFF;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lat = 1;
          e.res = o[1] ? 32'h0 : a;
        end else begin
          case (o)
            OPC_DIV:  e.res = 32'(sa / sbv);
            OPC_DIVU: e.res = a / b;
            OPC_REM:  e.res = 32'(sa % sbv);
            default:  e.res = a % b;
          endcase
        end
`else
        e.lat = 1;
        e.res = '0;
        e.ill = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rst in_ready", 64'(in_ready), 64'(0));
      check("rst out_valid", 64'(out_valid), 64'(0));
      check("rst Result", 64'(Result), 64'(0));
      check("rst illegal", 64'(illegal), 64'(0));
      sb.delete();
      lat_done = 0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!flush && (sb.size() == 0)));
      if (sb.size() == 0) begin
        check("out_valid idle", 64'(out_valid), 64'(0));
        check("illegal idle", 64'(illegal), 64'(0));
      end else if (out_valid) begin
        e = sb[0];
        if (!lat_done) begin
          check($sformatf("latency op%0d", e.op), 64'(cyc + 1 - e.acc_cyc), 64'(e.lat));
          lat_done = 1;
        end
        check($sformatf("Result op%0d", e.op), 64'(Result), 64'(e.res));
        check($sformatf("illegal op%0d", e.op), 64'(illegal), 64'(e.ill));
      end
      if (flush) begin
        if (sb.size() != 0) void'(sb.pop_front());
        lat_done = 0;
      end else begin
        if (sb.size() != 0 && out_valid && out_ready) begin
          void'(sb.pop_front());
          lat_done = 0;
        end
        if (in_valid && in_ready) begin
          sb.push_back(model(op, SrcA, SrcB, cyc + 1));
          acc_cnt++;
        end
      end
    end
  end

  task automatic wait_accept(input int start);
    for (int i = 0; i < 200 && acc_cnt == start; i++) @(posedge clk);
    check("accept", 64'(acc_cnt - start), 64'(1));
    #1;
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int start;
    start    = acc_cnt;
    op       = o;
    SrcA     = a;
    SrcB     = b;
    in_valid = 1'b1;
    wait_accept(start);
    in_valid = 1'b0;
    op       = 3'($urandom);
    SrcA     = $urandom;
    SrcB     = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    check("drain", 64'(sb.size()), 64'(0));
    #1;
  endtask

  logic [W-1:0] corners [6];

  initial begin
    int start;
    logic [W-1:0] ra, rb;
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; SrcA = '0; SrcB = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    send(OPC_MUL,    32'd7,          32'd6);          drain();
    send(OPC_MULH,   32'h8000_0000,  32'h8000_0000);  drain();
    send(OPC_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF);  drain();
    send(OPC_MULHSU, 32'hFFFF_FFFF,  32'd2);          drain();
    send(OPC_DIV,    32'hFFFF_FFF9,  32'd2);          drain();
    send(OPC_REM,    32'hFFFF_FFF9,  32'd2);          drain();
    send(OPC_DIVU,   32'd100,        32'd0);          drain();
    send(OPC_REMU,   32'd100,        32'd0);          drain();
    send(OPC_DIV,    32'h8000_0000,  32'hFFFF_FFFF);  drain();
    send(OPC_REM,    32'h8000_0000,  32'hFFFF_FFFF);  drain();
    send(OPC_DIVU,   32'hFFFF_FFFF,  32'd7);          drain();
    send(OPC_REM,    32'd17,         32'hFFFF_FFFB);  drain();

    // Consumer stalls five cycles in DONE; result must hold.
    out_ready = 1'b0;
    send(OPC_MUL, 32'd123456, 32'd789);
    for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
    check("stall out_valid", 64'(out_valid), 64'(1));
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Second request waits while the first is computing.
    start = acc_cnt;
    op = OPC_MUL; SrcA = 32'd11; SrcB = 32'd13; in_valid = 1'b1;
    wait_accept(start);
    op = OPC_MULHU; SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5678;
    wait_accept(start + 1);
    in_valid = 1'b0;
    drain();

    // Flush at CALC cycle 10 with a competing request; it is taken next cycle.
    send(OPC_MULHU, 32'hCAFE_F00D, 32'h0BAD_BEEF);
    repeat (9) @(posedge clk);
    #1;
    start = acc_cnt;
    flush = 1'b1; in_valid = 1'b1; op = OPC_MUL; SrcA = 32'd3; SrcB = 32'd5;
    @(posedge clk);
    #1 flush = 1'b0;
    wait_accept(start);
    in_valid = 1'b0;
    drain();

    for (int n = 0; n < 24; n++) begin
      ra = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
      send(3'($urandom_range(0, 7)), ra, rb);
      drain();
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
